// File: rtl/sfifo_pkg.sv
// Shared definitions for the sfifo family: FIFO geometry, counter width,
// and the read-credit helper used by the drain controller.
package sfifo_pkg;

  localparam int unsigned SFIFO_DW    = 8;
  localparam int unsigned SFIFO_DEPTH = 8;
  localparam int unsigned SFIFO_AW    = 3;
  localparam int unsigned SFIFO_CNT_W = 16;

  // Output buffer fill level as seen by the reader
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // True when buffered words plus the word still in flight leave a free slot
  function automatic logic has_credit(input logic [1:0] occ,
                                      input logic       inflight,
                                      input int unsigned depth);
    logic [2:0] sum;
    sum = {1'b0, occ} + {2'b00, inflight};
    return (32'(sum) < depth);
  endfunction

endpackage

// File: rtl/sfifo_reader_buf.sv
// Two-entry output buffer for sfifo_reader: write strobe appends at the tail,
// read strobe retires the head; 1-bit pointers wrap modulo 2.
module sfifo_reader_buf
  import sfifo_pkg::*;
#(
  parameter int unsigned DW = SFIFO_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [1:0]    occ,
  output logic [DW-1:0] head_data
);

  logic [DW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  occ_e          occ_q;

  // Storage, pointers and fill level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ_q  <= OCC_EMPTY;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (rd_en) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({wr_en, rd_en})
        2'b10:   occ_q <= (occ_q == OCC_EMPTY) ? OCC_ONE : OCC_FULL;
        2'b01:   occ_q <= (occ_q == OCC_FULL) ? OCC_ONE : OCC_EMPTY;
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Head word and fill level to the controller
  always_comb begin
    occ       = occ_q;
    head_data = mem[rd_ptr];
  end

endmodule

// File: rtl/sfifo_reader.sv
// Read-side drain controller for an 8-deep sfifo. Issues FIFO pops against
// buffer credit, captures the registered FIFO data one cycle later, and
// presents words on a valid/ready stream.
// Optional pop counter enabled by defining SFIFO_READER_CNT_EN.
module sfifo_reader
  import sfifo_pkg::*;
#(
  parameter int unsigned DW    = SFIFO_DW,
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   fifo_empty,
  input  logic [DW-1:0]          fifo_rdata,
  output logic                   fifo_rd_en,
  output logic                   m_valid,
  output logic [DW-1:0]          m_data,
  input  logic                   m_ready
`ifdef SFIFO_READER_CNT_EN
  ,
  output logic [SFIFO_CNT_W-1:0] pop_count
`endif
);

  logic          inflight;
  logic [1:0]    occ;
  logic [DW-1:0] head_data;
  logic          out_fire;

  sfifo_reader_buf #(
    .DW(DW)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (inflight),
    .wr_data  (fifo_rdata),
    .rd_en    (out_fire),
    .occ      (occ),
    .head_data(head_data)
  );

  // Stream outputs and read issue; an accepting consumer frees a slot this cycle
  always_comb begin
    m_valid    = (occ != 2'd0);
    m_data     = head_data;
    out_fire   = m_valid & m_ready;
    fifo_rd_en = enable & ~fifo_empty & (has_credit(occ, inflight, DEPTH) | out_fire);
  end

  // A read issued this cycle returns data next cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
    end
  end

`ifdef SFIFO_READER_CNT_EN
  logic [SFIFO_CNT_W-1:0] pop_cnt;

  // Free-running pop counter, wraps at all-ones
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pop_cnt <= '0;
    end else if (fifo_rd_en) begin
      pop_cnt <= pop_cnt + 1'b1;
    end
  end

  assign pop_count = pop_cnt;
`endif

endmodule

// File: tb/tb_sfifo_reader.sv
// Self-checking bench for sfifo_reader with a behavioural FIFO and a
// word-level reference model of the output stream.
module tb_sfifo_reader;
  import sfifo_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_rdata = '0;
  logic       fifo_rd_en;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready = 1'b0;
`ifdef SFIFO_READER_CNT_EN
  logic [15:0] pop_count;
`endif

  sfifo_reader #(.DW(8), .DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata),
    .fifo_rd_en(fifo_rd_en),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready)
`ifdef SFIFO_READER_CNT_EN
    ,
    .pop_count (pop_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural FIFO contents and write port
  logic [7:0] fq[$];
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;

  // Reference model: words popped but not yet delivered, with availability flag
  logic [7:0] pq[$];
  bit         pa[$];

  int pops = 0;
  int cyc = 0;
  logic [7:0] got[$];
  int got_cyc[$];
  int rd_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // FIFO model and reference model advance on each edge
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      fq.delete();
      pq.delete();
      pa.delete();
      fifo_empty <= 1'b1;
      fifo_rdata <= '0;
    end else begin
      cyc++;
      if (m_valid && m_ready) begin
        got.push_back(m_data);
        got_cyc.push_back(cyc);
      end
      if (pa.size() > 0 && pa[0] && m_ready) begin
        void'(pq.pop_front());
        void'(pa.pop_front());
      end
      foreach (pa[i]) pa[i] = 1'b1;
      if (fifo_rd_en && fq.size() > 0) begin
        pq.push_back(fq[0]);
        pa.push_back(1'b0);
        fifo_rdata <= fq.pop_front();
        pops++;
        rd_cyc.push_back(cyc);
      end
      if (wr_en && fq.size() < 8) fq.push_back(wr_data);
      fifo_empty <= (fq.size() == 0);
    end
  end

  // Per-cycle comparison against the model
  bit ev;
  bit er;
  always @(negedge clk) begin
    if (reset) begin
      ev = (pa.size() > 0) && pa[0];
      er = enable && (fq.size() > 0) && ((pq.size() < 2) || (ev && m_ready));
      chk("m_valid", m_valid, ev);
      if (ev) chk("m_data", m_data, pq[0]);
      chk("fifo_rd_en", fifo_rd_en, er);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    step(1);
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    enable = 1'b0;
    m_ready = 1'b0;
    wr_en = 1'b0;
    #1;
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    @(negedge clk);
    #2 reset = 1'b1;
    step(1);
  endtask

  initial begin : main
    int p0;
    int g0;
    logic [7:0] w[8];
    logic [7:0] t1[3];

    #2;
    chk("init_rd_en", fifo_rd_en, 0);
    chk("init_m_valid", m_valid, 0);
    chk("init_m_data", m_data, 0);
    #20 reset = 1'b1;
    step(1);

    // 1: three preloaded words stream back to back
    t1[0] = 8'h03; t1[1] = 8'h09; t1[2] = 8'h07;
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) write(t1[i]);
    p0 = pops; g0 = got.size();
    enable = 1'b1;
    step(8);
    chk("t1_pops", pops - p0, 3);
    chk("t1_rd_consec", rd_cyc[rd_cyc.size()-1] - rd_cyc[rd_cyc.size()-3], 2);
    chk("t1_count", got.size() - g0, 3);
    for (int i = 0; i < 3; i++) begin
      chk("t1_word", got[g0+i], t1[i]);
      chk("t1_gap", got_cyc[g0+i] - got_cyc[g0], i);
    end
    chk("t1_idle", m_valid, 0);

    // 2: consumer stalled, buffer fills then drains without gaps
    do_reset();
    for (int i = 0; i < 8; i++) begin
      w[i] = 8'($urandom);
      write(w[i]);
    end
    p0 = pops; g0 = got.size();
    enable = 1'b1;
    step(6);
    chk("t2_pops", pops - p0, 2);
    chk("t2_rd_stop", fifo_rd_en, 0);
    chk("t2_hold_v", m_valid, 1);
    chk("t2_hold_d", m_data, w[0]);
    m_ready = 1'b1;
    step(12);
    chk("t2_count", got.size() - g0, 8);
    for (int i = 0; i < 8; i++) begin
      chk("t2_word", got[g0+i], w[i]);
      chk("t2_gap", got_cyc[g0+i] - got_cyc[g0], i);
    end

    // 3: empty FIFO never popped; single word arrives two cycles after empty falls
    do_reset();
    enable = 1'b1;
    m_ready = 1'b1;
    p0 = pops;
    step(5);
    chk("t3_no_pop", pops - p0, 0);
    chk("t3_no_valid", m_valid, 0);
    write(8'h11);
    step(1);
    chk("t3_lat_early", m_valid, 0);
    step(1);
    chk("t3_lat_v", m_valid, 1);
    chk("t3_lat_d", m_data, 8'h11);

    // 4: enable dropped after the third pop
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) write(8'(i + 8'h40));
    p0 = pops; g0 = got.size();
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (pops - p0 >= 3) break;
      step(1);
    end
    enable = 1'b0;
    step(8);
    chk("t4_pops", pops - p0, 3);
    chk("t4_delivered", got.size() - g0, 3);
    chk("t4_left", fq.size(), 5);
    chk("t4_last", got[got.size()-1], 8'h42);

    // 5: asynchronous reset between edges
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) write(8'(i + 8'h60));
    enable = 1'b1;
    step(3);
    chk("t5_pre_valid", m_valid, 1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t5_async_valid", m_valid, 0);
    chk("t5_async_rd", fifo_rd_en, 0);
    chk("t5_async_data", m_data, 0);
    @(negedge clk);
    #2 reset = 1'b1;
    step(4);
    chk("t5_post_valid", m_valid, 0);

    // Randomized traffic checked by the per-cycle model
    do_reset();
    p0 = pops; g0 = got.size();
    for (int i = 0; i < 400; i++) begin
      enable = ($urandom_range(0, 3) != 0);
      m_ready = $urandom_range(0, 1);
      wr_en = ($urandom_range(0, 1) != 0) && (fq.size() < 8);
      wr_data = 8'($urandom);
      step(1);
    end
    wr_en = 1'b0;
    enable = 1'b1;
    m_ready = 1'b1;
    step(20);
    chk("rnd_drain", got.size() - g0, pops - p0);
    chk("rnd_idle", m_valid, 0);

`ifdef SFIFO_READER_CNT_EN
    // 6: pop counter value and wrap
    do_reset();
    enable = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) write(8'(i));
    step(10);
    chk("t6_count", pop_count, 8);
    force dut.pop_cnt = 16'hFFFF;
    #1 release dut.pop_cnt;
    write(8'hAA);
    step(5);
    chk("t6_wrap", pop_count, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
